// File: rtl/c499_pkg.sv
// Shared widths, frame payload layout and loader state encoding for the c499 front end.
package c499_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CHK_W   = 8;
   localparam int unsigned KEY_W   = 32;
   localparam int unsigned FRAME_W = DATA_W + CHK_W + 1;
   localparam int unsigned CNT_W   = 6;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT_KEY,
      SHIFT_FRAME,
      HOLD
   } state_t;

   // Serial order: data first (LSB first), then check bits, enable last
   typedef struct packed {
      logic              en;
      logic [CHK_W-1:0]  chk;
      logic [DATA_W-1:0] data;
   } frame_t;

endpackage

// File: rtl/sipo_shadow.sv
// Indexed serial-in shift register with a shadow copy that updates only on commit,
// so the parallel output never shows a partially loaded word.
module sipo_shadow #(
   parameter int unsigned W     = 32,
   parameter int unsigned IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift,
   input  logic [IDX_W-1:0] idx,
   input  logic             si,
   input  logic             commit,
   output logic [W-1:0]     q
);

   logic [W-1:0] sreg;
   logic [W-1:0] sreg_n;

   // Commit captures the bit being accepted this cycle along with the stored bits
   always_comb begin
      sreg_n = sreg;
      for (int i = 0; i < int'(W); i++) begin
         if (shift && (idx == IDX_W'(i))) begin
            sreg_n[i] = si;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         q    <= '0;
      end else begin
         sreg <= sreg_n;
         if (commit) begin
            q <= sreg_n;
         end
      end
   end

endmodule

// File: rtl/c499_frame_loader.sv
// Loads the activation key and the 41-bit codeword frame from one serial input and
// publishes each atomically to the c499 corrector; frames leave via valid/ready.
module c499_frame_loader
   import c499_pkg::*;
(
   input  logic              CK,
   input  logic              RST,
   input  logic              start_key,
   input  logic              start_frame,
   input  logic              abort,
   input  logic              si,
   input  logic              si_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data,
   output logic [CHK_W-1:0]  chk,
   output logic              en,
   output logic [KEY_W-1:0]  key,
   output logic              key_ok,
   output logic              out_valid,
   output logic              busy,
   output logic              err_nokey
);

   localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             key_ok_n, out_valid_n, err_n, busy_n;
   logic             shift_key, shift_frame, commit_key, commit_frame;
   frame_t           frame_q;

   always_ff @(posedge CK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         key_ok    <= 1'b0;
         out_valid <= 1'b0;
         err_nokey <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         key_ok    <= key_ok_n;
         out_valid <= out_valid_n;
         err_nokey <= err_n;
         busy      <= busy_n;
      end
   end

   // Counter holds at the terminal index after a commit instead of wrapping
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      key_ok_n     = key_ok;
      out_valid_n  = out_valid;
      err_n        = 1'b0;
      shift_key    = 1'b0;
      shift_frame  = 1'b0;
      commit_key   = 1'b0;
      commit_frame = 1'b0;
      case (state)
         IDLE: begin
            if (start_key) begin
               state_n = SHIFT_KEY;
               cnt_n   = '0;
            end else if (start_frame) begin
               if (key_ok) begin
                  state_n = SHIFT_FRAME;
                  cnt_n   = '0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         SHIFT_KEY: begin
            if (abort) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (si_valid) begin
               shift_key = 1'b1;
               if (cnt == KEY_LAST) begin
                  commit_key = 1'b1;
                  key_ok_n   = 1'b1;
                  state_n    = IDLE;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         SHIFT_FRAME: begin
            if (abort) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (si_valid) begin
               shift_frame = 1'b1;
               if (cnt == FRAME_LAST) begin
                  commit_frame = 1'b1;
                  out_valid_n  = 1'b1;
                  state_n      = HOLD;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n == SHIFT_KEY) || (state_n == SHIFT_FRAME);
   end

   sipo_shadow #(.W(KEY_W), .IDX_W(CNT_W)) u_key_sipo (
      .clk    (CK),
      .rst    (RST),
      .shift  (shift_key),
      .idx    (cnt),
      .si     (si),
      .commit (commit_key),
      .q      (key)
   );

   sipo_shadow #(.W(FRAME_W), .IDX_W(CNT_W)) u_frame_sipo (
      .clk    (CK),
      .rst    (RST),
      .shift  (shift_frame),
      .idx    (cnt),
      .si     (si),
      .commit (commit_frame),
      .q      (frame_q)
   );

   assign data = frame_q.data;
   assign chk  = frame_q.chk;
   assign en   = frame_q.en;

endmodule

// File: tb/tb_c499_frame_loader.sv
// Randomized bench for c499_frame_loader against a transaction-level model of the
// published key/frame registers.
module tb_c499_frame_loader;

   logic        CK = 1'b0;
   logic        RST = 1'b1;
   logic        start_key = 1'b0, start_frame = 1'b0, abort = 1'b0;
   logic        si = 1'b0, si_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] data;
   logic [7:0]  chk;
   logic        en;
   logic [31:0] key;
   logic        key_ok, out_valid, busy, err_nokey;

   c499_frame_loader dut (
      .CK          (CK),
      .RST         (RST),
      .start_key   (start_key),
      .start_frame (start_frame),
      .abort       (abort),
      .si          (si),
      .si_valid    (si_valid),
      .out_ready   (out_ready),
      .data        (data),
      .chk         (chk),
      .en          (en),
      .key         (key),
      .key_ok      (key_ok),
      .out_valid   (out_valid),
      .busy        (busy),
      .err_nokey   (err_nokey)
   );

   always #5 CK = ~CK;

   int total = 0;
   int bad   = 0;

   // Expected visible state, updated only when a whole transaction completes
   logic [31:0] m_key  = '0;
   logic        m_key_ok = 1'b0;
   logic [31:0] m_data = '0;
   logic [7:0]  m_chk  = '0;
   logic        m_en   = 1'b0;
   logic        m_ov   = 1'b0;

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".key"},       64'(key),       64'(m_key));
      check({tag, ".key_ok"},    64'(key_ok),    64'(m_key_ok));
      check({tag, ".data"},      64'(data),      64'(m_data));
      check({tag, ".chk"},       64'(chk),       64'(m_chk));
      check({tag, ".en"},        64'(en),        64'(m_en));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
      check({tag, ".busy"},      64'(busy),      64'(0));
      check({tag, ".err_nokey"}, 64'(err_nokey), 64'(0));
   endtask

   task automatic model_reset();
      m_key = '0; m_key_ok = 1'b0; m_data = '0; m_chk = '0; m_en = 1'b0; m_ov = 1'b0;
   endtask

   // One serial load; abort_at>=0 aborts before that bit, gap_at inserts a 3-cycle gap
   task automatic load(input bit is_key, input logic [40:0] val, input int abort_at,
                       input int gap_pct, input int gap_at, input bit both_starts);
      int n = is_key ? 32 : 41;
      start_key   = is_key | both_starts;
      start_frame = !is_key | both_starts;
      tick();
      start_key   = 1'b0;
      start_frame = 1'b0;
      check("start.busy", 64'(busy), 64'(1));
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            abort = 1'b1; si_valid = 1'b1; si = 1'($urandom);
            tick();
            abort = 1'b0; si_valid = 1'b0;
            check_all("abort");
            return;
         end
         for (int g = 0; g < 3 && i == gap_at; g++) begin
            si = 1'($urandom);
            tick();
            check("gap.busy", 64'(busy), 64'(1));
         end
         for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
            si = 1'($urandom);
            tick();
            check("rgap.busy", 64'(busy), 64'(1));
         end
         si = val[i]; si_valid = 1'b1;
         tick();
         si_valid = 1'b0;
         if (i < n - 1) begin
            check("mid.key",    64'(key),       64'(m_key));
            check("mid.key_ok", 64'(key_ok),    64'(m_key_ok));
            check("mid.data",   64'(data),      64'(m_data));
            check("mid.ov",     64'(out_valid), 64'(0));
         end
      end
      if (is_key) begin
         m_key = val[31:0]; m_key_ok = 1'b1;
         check_all("key_done");
      end else begin
         m_data = val[31:0]; m_chk = val[39:32]; m_en = val[40]; m_ov = 1'b1;
         check_all("frame_done");
      end
   endtask

   // Holds out_ready low while throwing junk at the inputs, then completes the handshake
   task automatic handshake(input int hold);
      out_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
         start_key = 1'($urandom); start_frame = 1'($urandom);
         si = 1'($urandom); si_valid = 1'($urandom); abort = 1'($urandom);
         tick();
         check_all("hold");
      end
      start_key = 1'b0; start_frame = 1'b0; si_valid = 1'b0; abort = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      m_ov = 1'b0;
      check_all("released");
   endtask

   initial begin
      logic [40:0] fv;
      // Reset
      tick(); tick();
      check_all("reset");
      RST = 1'b0;
      tick();
      check_all("post_reset");

      // Frame request with no key
      start_frame = 1'b1;
      tick();
      start_frame = 1'b0;
      check("nokey.err",  64'(err_nokey), 64'(1));
      check("nokey.busy", 64'(busy),      64'(0));
      tick();
      check_all("nokey.after");

      // Directed key, frame, hold, abort
      load(1'b1, 41'(32'hA5C3_0F96), -1, 0, 16, 1'b0);
      load(1'b0, {1'b1, 8'h5A, 32'hDEAD_BEEF}, -1, 0, -1, 1'b0);
      handshake(5);
      load(1'b0, {1'b0, 8'hC3, 32'h1234_5678}, 20, 0, -1, 1'b0);
      fv = {1'($urandom), 8'($urandom), 32'($urandom)};
      load(1'b0, fv, -1, 20, -1, 1'b0);
      handshake(2);

      // Random transaction mix
      for (int t = 0; t < 40; t++) begin
         int op = int'($urandom_range(2));
         int ab = ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1;
         fv = {1'($urandom), 8'($urandom), 32'($urandom)};
         if (op == 0) begin
            load(1'b1, fv, (ab > 31) ? -1 : ab, 30, -1, 1'b0);
         end else if (op == 1) begin
            load(1'b0, fv, ab, 30, -1, 1'b0);
            if (m_ov) handshake(int'($urandom_range(4)));
         end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_all("idle_abort");
         end
      end

      // Both starts together load a key; reset mid reload clears everything
      fv = 41'($urandom);
      load(1'b1, fv, -1, 0, -1, 1'b1);
      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      for (int i = 0; i < 15; i++) begin
         si = 1'($urandom); si_valid = 1'b1;
         tick();
      end
      si_valid = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      model_reset();
      check_all("mid_reset");
      start_frame = 1'b1;
      tick();
      start_frame = 1'b0;
      check("reset_nokey.err", 64'(err_nokey), 64'(1));
      tick();
      check_all("reset_nokey.after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
